frame_buffer_ram_arbiter: RTL and testbench

//  Downstream of the row/column-to-RAM address mapper. Queues byte-wide pixel

---
 rtl/frame_buffer_ram_arbiter.sv | 170 +++++++++++++++++
 tb/tb_frame_buffer_ram_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : frame_buffer_ram_arbiter
// Purpose  : Queues byte-wide pixel writes in a small FIFO and arbitrates
//            them against display-refresh reads onto one 16-bit synchronous
//            graphics RAM port. Display reads always win, so the video scan
//            never stalls.
// Ports    : Clock, Reset_L (async, active low)
//            WrReq/WrAddress/WrByteSelect/WrColour -> pixel write request
//            WrReady   : FIFO can accept (write taken on WrReq & WrReady)
//            RdReq/RdAddress                       -> display read request
//            RdData/RdValid : read word, valid 3 cycles after RdReq
//            RamAddr/RamWrData/RamWE/RamBE         -> registered RAM controls
//            RamRdData : RAM read data, one cycle after RamAddr
// Options  : WRITE_COALESCE_EN - merge two queued writes to the same word
//            with opposite byte selects into one full-word write.
// Revision : 1.0 - initial release
// ============================================================================
module frame_buffer_ram_arbiter #(
    parameter int ADDR_W     = 18,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              Clock,
    input  logic              Reset_L,
    input  logic              WrReq,
    input  logic [ADDR_W-1:0] WrAddress,
    input  logic              WrByteSelect,
    input  logic [7:0]        WrColour,
    output logic              WrReady,
    input  logic              RdReq,
    input  logic [ADDR_W-1:0] RdAddress,
    output logic [15:0]       RdData,
    output logic              RdValid,
    output logic [ADDR_W-1:0] RamAddr,
    output logic [15:0]       RamWrData,
    output logic              RamWE,
    output logic [1:0]        RamBE,
    input  logic [15:0]       RamRdData
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    // Bit 0 marks a read on the RAM port, bit 1 a write; each bit is used
    // directly as a registered control, so no decode sits behind the flops.
    localparam logic [1:0] c_ST_IDLE  = 2'b00;
    localparam logic [1:0] c_ST_READ  = 2'b01;
    localparam logic [1:0] c_ST_WRITE = 2'b10;

    // Pending-write FIFO
    logic [ADDR_W-1:0]  r_fifo_addr [FIFO_DEPTH];
    logic               r_fifo_sel  [FIFO_DEPTH];
    logic [7:0]         r_fifo_col  [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic [1:0]         r_state;
    logic               r_rd_pend;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic [c_CNT_W-1:0] w_pop_n;
    logic [1:0]         w_state_nxt;
    logic [ADDR_W-1:0]  w_addr_nxt;
    logic [15:0]        w_wdata_nxt;
    logic [1:0]         w_be_nxt;

    assign w_full  = (r_count == c_CNT_W'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    // A full FIFO refuses a push even when a pop happens in the same cycle.
    assign w_push  = WrReq & ~w_full;
    assign WrReady = ~w_full;
    assign RamWE   = r_state[1];

`ifdef WRITE_COALESCE_EN
    logic [c_PTR_W-1:0] w_next_ptr;
    logic               w_coalesce;

    // Pointer arithmetic wraps naturally because the depth is a power of two.
    assign w_next_ptr = r_rd_ptr + c_PTR_W'(1);
    assign w_coalesce = (r_count >= c_CNT_W'(2))
                      && (r_fifo_addr[r_rd_ptr] == r_fifo_addr[w_next_ptr])
                      && (r_fifo_sel[r_rd_ptr] != r_fifo_sel[w_next_ptr]);
`endif

    // Issue decision: read beats write, write beats idle.
    always_comb begin
        w_state_nxt = c_ST_IDLE;
        w_pop_n     = '0;
        w_addr_nxt  = RamAddr;
        w_wdata_nxt = RamWrData;
        w_be_nxt    = 2'b00;
        if (RdReq) begin
            w_state_nxt = c_ST_READ;
            w_addr_nxt  = RdAddress;
            w_be_nxt    = 2'b11;
        end else if (!w_empty) begin
            w_state_nxt = c_ST_WRITE;
            w_pop_n     = c_CNT_W'(1);
            w_addr_nxt  = r_fifo_addr[r_rd_ptr];
            w_wdata_nxt = {r_fifo_col[r_rd_ptr], r_fifo_col[r_rd_ptr]};
            w_be_nxt    = r_fifo_sel[r_rd_ptr] ? 2'b10 : 2'b01;
`ifdef WRITE_COALESCE_EN
            if (w_coalesce) begin
                w_pop_n     = c_CNT_W'(2);
                w_be_nxt    = 2'b11;
                // The entry with ByteSelect=1 owns the upper byte.
                w_wdata_nxt = r_fifo_sel[r_rd_ptr]
                            ? {r_fifo_col[r_rd_ptr], r_fifo_col[w_next_ptr]}
                            : {r_fifo_col[w_next_ptr], r_fifo_col[r_rd_ptr]};
            end
`endif
        end
    end

    // FIFO payload needs no reset: occupancy alone defines what is valid.
    always_ff @(posedge Clock) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= WrAddress;
            r_fifo_sel[r_wr_ptr]  <= WrByteSelect;
            r_fifo_col[r_wr_ptr]  <= WrColour;
        end
    end

    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + c_PTR_W'(w_push);
            r_rd_ptr <= r_rd_ptr + w_pop_n[c_PTR_W-1:0];
            r_count  <= r_count + c_CNT_W'(w_push) - w_pop_n;
        end
    end

    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            r_state   <= c_ST_IDLE;
            RamAddr   <= '0;
            RamWrData <= '0;
            RamBE     <= 2'b00;
        end else begin
            r_state   <= w_state_nxt;
            RamAddr   <= w_addr_nxt;
            RamWrData <= w_wdata_nxt;
            RamBE     <= w_be_nxt;
        end
    end

    // Read return pipe: a read on the RAM port this cycle returns data next
    // cycle, which is captured into RdData the cycle after that.
    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            r_rd_pend <= 1'b0;
            RdValid   <= 1'b0;
            RdData    <= '0;
        end else begin
            r_rd_pend <= r_state[0];
            RdValid   <= r_rd_pend;
            if (r_rd_pend) begin
                RdData <= RamRdData;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_buffer_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_buffer_ram_arbiter
// Purpose  : Self-checking bench for frame_buffer_ram_arbiter. Expected RAM
//            writes and read returns are queued when stimulus is driven and
//            compared when the DUT produces them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_buffer_ram_arbiter;

    localparam int ADDR_W = 18;

    logic              Clock = 1'b0;
    logic              Reset_L = 1'b0;
    logic              WrReq = 1'b0;
    logic [ADDR_W-1:0] WrAddress = '0;
    logic              WrByteSelect = 1'b0;
    logic [7:0]        WrColour = '0;
    logic              WrReady;
    logic              RdReq = 1'b0;
    logic [ADDR_W-1:0] RdAddress = '0;
    logic [15:0]       RdData;
    logic              RdValid;
    logic [ADDR_W-1:0] RamAddr;
    logic [15:0]       RamWrData;
    logic              RamWE;
    logic [1:0]        RamBE;
    logic [15:0]       RamRdData = '0;

    frame_buffer_ram_arbiter #(.ADDR_W(ADDR_W), .FIFO_DEPTH(4)) dut (
        .Clock(Clock), .Reset_L(Reset_L),
        .WrReq(WrReq), .WrAddress(WrAddress), .WrByteSelect(WrByteSelect),
        .WrColour(WrColour), .WrReady(WrReady),
        .RdReq(RdReq), .RdAddress(RdAddress), .RdData(RdData), .RdValid(RdValid),
        .RamAddr(RamAddr), .RamWrData(RamWrData), .RamWE(RamWE), .RamBE(RamBE),
        .RamRdData(RamRdData)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    // RAM model: word content is a fixed function of its address.
    always @(posedge Clock) RamRdData <= RamAddr[15:0] ^ 16'hEDCB;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [1:0]        be;
        logic [15:0]       data;
    } wexp_t;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } rexp_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              sel;
        logic [7:0]        col;
        logic [1:0]        be;
        logic [15:0]       data;
    } wvec_t;

    wexp_t wq[$];
    rexp_t rq[$];
    wvec_t tbl[6];

    int n_pass = 0;
    int n_total = 0;
    bit auto_wexp = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Track what the RAM port should be doing in response to RdReq.
    logic              rdreq_d;
    logic [ADDR_W-1:0] rdaddr_d;
    always @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            rdreq_d  <= 1'b0;
            rdaddr_d <= '0;
        end else begin
            rdreq_d  <= RdReq;
            rdaddr_d <= RdAddress;
        end
    end

    // Monitor / scoreboard, sampled on the falling edge.
    always @(negedge Clock) begin
        if (Reset_L) begin
            if (rdreq_d) begin
                chk("read_issue_we", RamWE, 0);
                chk("read_issue_be", RamBE, 2'b11);
                chk("read_issue_addr", RamAddr, rdaddr_d);
            end
            if (RamWE) begin
                chk("write_expected", (wq.size() != 0), 1);
                if (wq.size() != 0) begin
                    wexp_t e;
                    e = wq.pop_front();
                    chk("write_addr", RamAddr, e.addr);
                    chk("write_be", RamBE, e.be);
                    chk("write_data", RamWrData, e.data);
                end
            end
            if (RdValid) begin
                chk("read_expected", (rq.size() != 0), 1);
                if (rq.size() != 0) begin
                    rexp_t r;
                    r = rq.pop_front();
                    chk("read_data", RdData, r.data);
                    chk("read_latency_cycle", cyc, r.cyc);
                end
            end
        end
    end

    // Record expectations for whatever is being driven, then advance a cycle.
    task automatic step();
        if (RdReq) rq.push_back('{RdAddress[15:0] ^ 16'hEDCB, cyc + 3});
        if (auto_wexp && WrReq && WrReady)
            wq.push_back('{WrAddress, (WrByteSelect ? 2'b10 : 2'b01), {WrColour, WrColour}});
        @(posedge Clock);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 20; k++) begin
            if (wq.size() == 0 && rq.size() == 0) break;
            step();
        end
        chk("drain_writes", wq.size(), 0);
        chk("drain_reads", rq.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wrready"}, WrReady, 1);
        chk({tag, "_rdvalid"}, RdValid, 0);
        chk({tag, "_rddata"}, RdData, 0);
        chk({tag, "_ramaddr"}, RamAddr, 0);
        chk({tag, "_ramwrdata"}, RamWrData, 0);
        chk({tag, "_ramwe"}, RamWE, 0);
        chk({tag, "_rambe"}, RamBE, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{18'h00010, 1'b0, 8'h5A, 2'b01, 16'h5A5A};
        tbl[1] = '{18'h00011, 1'b1, 8'hC3, 2'b10, 16'hC3C3};
        tbl[2] = '{18'h3FFFF, 1'b0, 8'hFF, 2'b01, 16'hFFFF};
        tbl[3] = '{18'h00000, 1'b1, 8'h00, 2'b10, 16'h0000};
        tbl[4] = '{18'h2AAAA, 1'b1, 8'h81, 2'b10, 16'h8181};
        tbl[5] = '{18'h15555, 1'b0, 8'h7E, 2'b01, 16'h7E7E};

        // Power-on reset state
        repeat (2) @(posedge Clock);
        #1;
        check_reset_outputs("por");
        Reset_L = 1'b1;
        step();

        // Single writes: issued two edges after WrReq, exact controls checked
        for (int i = 0; i < 6; i++) begin
            WrAddress    = tbl[i].addr;
            WrByteSelect = tbl[i].sel;
            WrColour     = tbl[i].col;
            WrReq        = 1'b1;
            chk($sformatf("tbl%0d_ready", i), WrReady, 1);
            wq.push_back('{tbl[i].addr, tbl[i].be, tbl[i].data});
            @(posedge Clock); #1;
            WrReq = 1'b0;
            @(posedge Clock); #1;
            chk($sformatf("tbl%0d_we", i), RamWE, 1);
            chk($sformatf("tbl%0d_addr", i), RamAddr, tbl[i].addr);
            chk($sformatf("tbl%0d_be", i), RamBE, tbl[i].be);
            chk($sformatf("tbl%0d_data", i), RamWrData, tbl[i].data);
            step();
            step();
        end
        drain();

        // Back-to-back reads, including the top address
        RdReq = 1'b1;
        RdAddress = 18'h3FFFF;
        repeat (3) step();
        RdAddress = 18'h00000;
        step();
        RdAddress = 18'h12345;
        step();
        RdReq = 1'b0;
        drain();

        // Fill the FIFO behind a continuous read, then release
        auto_wexp = 1'b1;
        RdReq = 1'b1;
        RdAddress = 18'h00ABC;
        for (int i = 0; i < 5; i++) begin
            WrReq        = 1'b1;
            WrAddress    = 18'h00100 + 18'(i);
            WrByteSelect = i[0];
            WrColour     = 8'h10 + 8'(i);
            chk($sformatf("fill%0d_ready", i), WrReady, (i < 4) ? 1 : 0);
            step();
        end
        WrReq = 1'b0;
        chk("full_ready", WrReady, 0);
        RdReq = 1'b0;
        step();
        chk("ready_after_pop", WrReady, 1);
        drain();

        // Two byte writes to the same word
        auto_wexp = 1'b0;
        RdReq = 1'b1;
        RdAddress = 18'h00055;
        WrReq = 1'b1;
        WrAddress = 18'h00020;
        WrByteSelect = 1'b0;
        WrColour = 8'h11;
        step();
        WrByteSelect = 1'b1;
        WrColour = 8'h22;
        step();
        WrReq = 1'b0;
`ifdef WRITE_COALESCE_EN
        wq.push_back('{18'h00020, 2'b11, 16'h2211});
`else
        wq.push_back('{18'h00020, 2'b01, 16'h1111});
        wq.push_back('{18'h00020, 2'b10, 16'h2222});
`endif
        RdReq = 1'b0;
        drain();

        // Reset in the middle of traffic
        auto_wexp = 1'b1;
        RdReq = 1'b1;
        RdAddress = 18'h00777;
        WrReq = 1'b1;
        WrAddress = 18'h00300;
        WrByteSelect = 1'b0;
        WrColour = 8'h44;
        step();
        WrAddress = 18'h00301;
        step();
        WrReq = 1'b0;
        step();
        #3;
        Reset_L = 1'b0;
        #1;
        check_reset_outputs("midrst");
        wq.delete();
        rq.delete();
        RdReq = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        Reset_L = 1'b1;
        repeat (8) step();
        chk("post_reset_ready", WrReady, 1);
        chk("post_reset_we", RamWE, 0);
        chk("post_reset_rdvalid", RdValid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
